mult_rr_arbiter: RTL and testbench

Two-client round-robin arbiter and sequencer for the shared A×B multiplier datapath. Each client presents operand pairs over a REQ/ACK handshake. The block grants one client per cycle and pushes the operands through a registered issue stage into the shared multiplier. Each product lands in a per-client result register drained with a VALID/RDY handshake. Per-client completion counters are provided for host monitoring.

---
 rtl/mult_rr_arbiter_pkg.sv | 11 +
 rtl/mult_rr_arbiter_mult.sv | 14 +
 rtl/mult_rr_arbiter_rr_arb2.sv | 36 +++
 rtl/mult_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_mult_rr_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult_rr_arbiter_pkg.sv
// Shared constants for the two-client multiplier arbiter.
// Client indices and default datapath widths.
package mult_rr_arbiter_pkg;

    localparam int CLIENT0   = 0;
    localparam int CLIENT1   = 1;
    localparam int W_DEF     = 8;
    localparam int CNT_W_DEF = 16;
    localparam int PW_DEF    = 2 * W_DEF;

endpackage

// File: rtl/mult_rr_arbiter_mult.sv
// Combinational unsigned multiplier for the shared datapath.
// Full-width product, no truncation.
module mult #(
    parameter int W = 8
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    // Zero-extend operands so the product is formed at full width
    assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule

// File: rtl/mult_rr_arbiter_rr_arb2.sv
// Two-way round-robin grant logic.
// Owns the pointer to the most recently granted client.
module rr_arb2 (
    input  logic CLK,
    input  logic RST,
    input  logic elig0,
    input  logic elig1,
    output logic grant0,
    output logic grant1
);

    logic last_q;
    logic last_d;

    // Grant the sole eligible client, or on a tie the one not served last
    always_comb begin
        grant0 = elig0 && (!elig1 || last_q);
        grant1 = elig1 && (!elig0 || !last_q);
        last_d = last_q;
        if (grant0) begin
            last_d = 1'b0;
        end else if (grant1) begin
            last_d = 1'b1;
        end
    end

    // Pointer starts at client 1 so client 0 wins the first tie
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mult_rr_arbiter.sv
// Two-client round-robin sequencer for the shared multiplier.
// Grant -> issue register -> multiply -> per-client result register.
module mult_rr_arbiter
    import mult_rr_arbiter_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             REQ0,
    input  logic [W-1:0]     A0,
    input  logic [W-1:0]     B0,
    output logic             ACK0,
    output logic [2*W-1:0]   X0,
    output logic             X0_VALID,
    input  logic             X0_RDY,
    input  logic             REQ1,
    input  logic [W-1:0]     A1,
    input  logic [W-1:0]     B1,
    output logic             ACK1,
    output logic [2*W-1:0]   X1,
    output logic             X1_VALID,
    input  logic             X1_RDY,
    output logic             BUSY,
    output logic [CNT_W-1:0] CNT0,
    output logic [CNT_W-1:0] CNT1
);

    localparam logic TAG0 = 1'(CLIENT0);
    localparam logic TAG1 = 1'(CLIENT1);

    logic             op_valid_q, op_valid_d;
    logic             op_tag_q, op_tag_d;
    logic [W-1:0]     op_a_q, op_a_d;
    logic [W-1:0]     op_b_q, op_b_d;
    logic [2*W-1:0]   x0_q, x0_d;
    logic [2*W-1:0]   x1_q, x1_d;
    logic             x0_valid_q, x0_valid_d;
    logic             x1_valid_q, x1_valid_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic           inflight0, inflight1;
    logic           elig0, elig1;
    logic           grant0, grant1;
    logic           wr0, wr1;
    logic           drain0, drain1;
    logic [2*W-1:0] prod;

    // A client may be granted only if its slot is empty or draining now
    always_comb begin
        inflight0 = op_valid_q && (op_tag_q == TAG0);
        inflight1 = op_valid_q && (op_tag_q == TAG1);
        elig0 = EN && REQ0 && !inflight0 && (!x0_valid_q || X0_RDY);
        elig1 = EN && REQ1 && !inflight1 && (!x1_valid_q || X1_RDY);
    end

    rr_arb2 u_arb (
        .CLK    (CLK),
        .RST    (RST),
        .elig0  (elig0),
        .elig1  (elig1),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    mult #(.W(W)) u_mult (
        .a (op_a_q),
        .b (op_b_q),
        .p (prod)
    );

    // Issue stage captures the granted client's operands
    always_comb begin
        op_valid_d = grant0 || grant1;
        op_tag_d   = op_tag_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        if (grant0) begin
            op_tag_d = TAG0;
            op_a_d   = A0;
            op_b_d   = B0;
        end else if (grant1) begin
            op_tag_d = TAG1;
            op_a_d   = A1;
            op_b_d   = B1;
        end
    end

    // Result slots: a landing write wins over a same-edge drain
    always_comb begin
        wr0        = op_valid_q && (op_tag_q == TAG0);
        wr1        = op_valid_q && (op_tag_q == TAG1);
        drain0     = x0_valid_q && X0_RDY;
        drain1     = x1_valid_q && X1_RDY;
        x0_d       = wr0 ? prod : x0_q;
        x1_d       = wr1 ? prod : x1_q;
        x0_valid_d = wr0 || (x0_valid_q && !X0_RDY);
        x1_valid_d = wr1 || (x1_valid_q && !X1_RDY);
        cnt0_d     = drain0 ? cnt0_q + CNT_W'(1) : cnt0_q;
        cnt1_d     = drain1 ? cnt1_q + CNT_W'(1) : cnt1_q;
    end

    // Pipeline, result and counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_valid_q <= 1'b0;
            op_tag_q   <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            x0_q       <= '0;
            x1_q       <= '0;
            x0_valid_q <= 1'b0;
            x1_valid_q <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            op_valid_q <= op_valid_d;
            op_tag_q   <= op_tag_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            x0_valid_q <= x0_valid_d;
            x1_valid_q <= x1_valid_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    assign ACK0     = grant0;
    assign ACK1     = grant1;
    assign X0       = x0_q;
    assign X1       = x1_q;
    assign X0_VALID = x0_valid_q;
    assign X1_VALID = x1_valid_q;
    assign CNT0     = cnt0_q;
    assign CNT1     = cnt1_q;
    assign BUSY     = op_valid_q || x0_valid_q || x1_valid_q;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed bench for mult_rr_arbiter.
// Cycle table plus reset-mid-operation sequence.
module tb_mult_rr_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic        REQ0, REQ1;
    logic [7:0]  A0, B0, A1, B1;
    logic        ACK0, ACK1;
    logic [15:0] X0, X1;
    logic        X0_VALID, X1_VALID;
    logic        X0_RDY, X1_RDY;
    logic        BUSY;
    logic [15:0] CNT0, CNT1;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic        en;
        logic        r0;
        logic [7:0]  a0;
        logic [7:0]  b0;
        logic        y0;
        logic        r1;
        logic [7:0]  a1;
        logic [7:0]  b1;
        logic        y1;
        logic        ack0;
        logic        ack1;
        logic        v0;
        logic [15:0] x0;
        logic        v1;
        logic [15:0] x1;
        logic        busy;
        logic [15:0] cnt0;
        logic [15:0] cnt1;
    } vec_t;

    vec_t vq[$];

    mult_rr_arbiter #(.W(8), .CNT_W(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .REQ0     (REQ0),
        .A0       (A0),
        .B0       (B0),
        .ACK0     (ACK0),
        .X0       (X0),
        .X0_VALID (X0_VALID),
        .X0_RDY   (X0_RDY),
        .REQ1     (REQ1),
        .A1       (A1),
        .B1       (B1),
        .ACK1     (ACK1),
        .X1       (X1),
        .X1_VALID (X1_VALID),
        .X1_RDY   (X1_RDY),
        .BUSY     (BUSY),
        .CNT0     (CNT0),
        .CNT1     (CNT1)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got %0d expected %0d",
                     nm, idx, act, exp);
        end
    endtask

    task automatic add(
        input logic en, input logic r0, input logic [7:0] a0,
        input logic [7:0] b0, input logic y0, input logic r1,
        input logic [7:0] a1, input logic [7:0] b1, input logic y1,
        input logic ack0, input logic ack1, input logic v0,
        input logic [15:0] x0, input logic v1, input logic [15:0] x1,
        input logic busy, input logic [15:0] cnt0,
        input logic [15:0] cnt1);
        vec_t v;
        v = '{en, r0, a0, b0, y0, r1, a1, b1, y1,
              ack0, ack1, v0, x0, v1, x1, busy, cnt0, cnt1};
        vq.push_back(v);
    endtask

    task automatic idle();
        add(1, 0, 0, 0, 1, 0, 0, 0, 1,
            0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drive(input vec_t v);
        EN = v.en;
        REQ0 = v.r0; A0 = v.a0; B0 = v.b0; X0_RDY = v.y0;
        REQ1 = v.r1; A1 = v.a1; B1 = v.b1; X1_RDY = v.y1;
    endtask

    task automatic check_all(input int i, input vec_t v);
        chk("ACK0", i, 32'(ACK0), 32'(v.ack0));
        chk("ACK1", i, 32'(ACK1), 32'(v.ack1));
        chk("X0_VALID", i, 32'(X0_VALID), 32'(v.v0));
        chk("X0", i, 32'(X0), 32'(v.x0));
        chk("X1_VALID", i, 32'(X1_VALID), 32'(v.v1));
        chk("X1", i, 32'(X1), 32'(v.x1));
        chk("BUSY", i, 32'(BUSY), 32'(v.busy));
        chk("CNT0", i, 32'(CNT0), 32'(v.cnt0));
        chk("CNT1", i, 32'(CNT1), 32'(v.cnt1));
    endtask

    initial begin
        // single op
        add(1,1,3,5,1, 0,0,0,1, 1,0, 0,0, 0,0, 0, 0,0);
        add(1,0,3,5,1, 0,0,0,1, 0,0, 0,0, 0,0, 1, 0,0);
        add(1,0,0,0,1, 0,0,0,1, 0,0, 1,15, 0,0, 1, 0,0);
        add(1,0,0,0,1, 0,0,0,1, 0,0, 0,15, 0,0, 0, 1,0);
        // alternation, pointer last=0 so client 1 first
        add(1,1,2,3,1, 1,4,5,1, 0,1, 0,15, 0,0, 0, 1,0);
        add(1,1,2,3,1, 1,4,5,1, 1,0, 0,15, 0,0, 1, 1,0);
        add(1,1,2,3,1, 1,4,5,1, 0,1, 0,15, 1,20, 1, 1,0);
        add(1,1,2,3,1, 1,4,5,1, 1,0, 1,6, 0,20, 1, 1,1);
        add(1,1,2,3,1, 1,4,5,1, 0,1, 0,6, 1,20, 1, 2,1);
        add(1,0,0,0,1, 0,0,0,1, 0,0, 1,6, 0,20, 1, 2,2);
        // width boundary, tie goes to client 0
        add(1,1,0,200,1, 1,255,255,1, 1,0, 0,6, 1,20, 1, 3,2);
        add(1,1,0,200,1, 1,255,255,1, 0,1, 0,6, 0,20, 1, 3,3);
        add(1,0,0,0,1, 0,0,0,1, 0,0, 1,0, 0,20, 1, 3,3);
        add(1,0,0,0,1, 0,0,0,1, 0,0, 0,0, 1,65025, 1, 4,3);
        add(1,0,0,0,1, 0,0,0,1, 0,0, 0,0, 0,65025, 0, 4,4);
        // backpressure on client 0
        add(1,1,7,9,0, 0,0,0,1, 1,0, 0,0, 0,65025, 0, 4,4);
        add(1,1,7,9,0, 0,0,0,1, 0,0, 0,0, 0,65025, 1, 4,4);
        add(1,1,7,9,0, 0,0,0,1, 0,0, 1,63, 0,65025, 1, 4,4);
        add(1,1,10,10,0, 0,0,0,1, 0,0, 1,63, 0,65025, 1, 4,4);
        add(1,1,10,10,1, 0,0,0,1, 1,0, 1,63, 0,65025, 1, 4,4);
        add(1,0,10,10,1, 0,0,0,1, 0,0, 0,63, 0,65025, 1, 5,4);
        add(1,0,0,0,1, 0,0,0,1, 0,0, 1,100, 0,65025, 1, 5,4);
        add(1,0,0,0,1, 0,0,0,1, 0,0, 0,100, 0,65025, 0, 6,4);
        // enable gating
        for (int k = 0; k < 5; k++) begin
            add(0,1,1,1,1, 1,2,2,1, 0,0, 0,100, 0,65025, 0, 6,4);
        end
        add(1,1,1,1,1, 1,2,2,1, 0,1, 0,100, 0,65025, 0, 6,4);
        add(0,1,1,1,1, 1,2,2,1, 0,0, 0,100, 0,65025, 1, 6,4);
        add(0,1,1,1,1, 1,2,2,1, 0,0, 0,100, 1,4, 1, 6,4);
        add(0,0,0,0,1, 0,0,0,1, 0,0, 0,100, 0,4, 0, 6,5);

        // reset and reset-state check
        RST = 1'b1;
        EN = 0; REQ0 = 0; REQ1 = 0;
        A0 = 0; B0 = 0; A1 = 0; B1 = 0;
        X0_RDY = 0; X1_RDY = 0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst ACK0", 0, 32'(ACK0), 0);
        chk("rst ACK1", 0, 32'(ACK1), 0);
        chk("rst X0_VALID", 0, 32'(X0_VALID), 0);
        chk("rst X1_VALID", 0, 32'(X1_VALID), 0);
        chk("rst X0", 0, 32'(X0), 0);
        chk("rst X1", 0, 32'(X1), 0);
        chk("rst BUSY", 0, 32'(BUSY), 0);
        chk("rst CNT0", 0, 32'(CNT0), 0);
        chk("rst CNT1", 0, 32'(CNT1), 0);

        foreach (vq[i]) begin
            @(posedge CLK);
            #1 drive(vq[i]);
            @(negedge CLK);
            check_all(i, vq[i]);
        end

        // reset mid-op: grant client 0, then reset during issue
        @(posedge CLK);
        #1 EN = 1; REQ0 = 1; A0 = 9; B0 = 9; REQ1 = 0;
        X0_RDY = 1; X1_RDY = 1;
        @(negedge CLK);
        chk("midrst ACK0", 0, 32'(ACK0), 1);
        @(posedge CLK);
        #1 RST = 1'b1; REQ0 = 0;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("midrst X0_VALID", 0, 32'(X0_VALID), 0);
        chk("midrst X0", 0, 32'(X0), 0);
        chk("midrst BUSY", 0, 32'(BUSY), 0);
        chk("midrst CNT0", 0, 32'(CNT0), 0);
        chk("midrst CNT1", 0, 32'(CNT1), 0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk("midrst X0_VALID late", k, 32'(X0_VALID), 0);
            chk("midrst CNT0 late", k, 32'(CNT0), 0);
        end

        // pointer back at last=1: tie goes to client 0
        @(posedge CLK);
        #1 REQ0 = 1; A0 = 6; B0 = 7;
        REQ1 = 1; A1 = 8; B1 = 8;
        @(negedge CLK);
        chk("post-rst ACK0", 0, 32'(ACK0), 1);
        chk("post-rst ACK1", 0, 32'(ACK1), 0);
        @(posedge CLK);
        #1 REQ0 = 0; REQ1 = 0;
        @(posedge CLK);
        @(negedge CLK);
        chk("post-rst X0_VALID", 0, 32'(X0_VALID), 1);
        chk("post-rst X0", 0, 32'(X0), 42);
        @(posedge CLK);
        @(negedge CLK);
        chk("post-rst CNT0", 0, 32'(CNT0), 1);
        chk("post-rst BUSY", 0, 32'(BUSY), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
